// File: rtl/example_5_4_decoder_pkg.sv
// Shared constants and types for the example 5.4 serial parity decoder.
package example_5_4_pkg;

  // LED positions on the EGO1 board for each piece of visible state
  localparam int LED_D1     = 0;
  localparam int LED_D2     = 1;
  localparam int LED_D3     = 2;
  localparam int LED_Z      = 3;
  localparam int LED_ZERO   = 4;
  localparam int LED_LOOP   = 5;
  localparam int LED_ERR    = 6;
  localparam int LED_BTN    = 7;
  localparam int LED_CNT_LO = 8;

  // Switch positions
  localparam int SW_SERIAL = 0;
  localparam int SW_CLEAR  = 6;
  localparam int SW_LOOP   = 7;

  // 10 ms of stable samples at 100 MHz
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Three-stage history: b1 is the newest bit, b3 the oldest
  typedef struct packed {
    logic b3;
    logic b2;
    logic b1;
  } shift3_t;

  // Push a new bit into the newest position, dropping the oldest
  function automatic shift3_t shiftIn(input shift3_t s, input logic bitIn);
    shift3_t n;
    n.b3 = s.b2;
    n.b2 = s.b1;
    n.b1 = bitIn;
    return n;
  endfunction

endpackage

// File: rtl/example_5_4_decoder_btn_debounce.sv
// Button synchronizer, debouncer and press-edge pulse generator.
module btn_debounce
  import example_5_4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic cp,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_levelPrev;

  // Two-flop synchronizer for the raw, asynchronous button
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count how long the input has disagreed with the accepted level; any bounce back restarts it
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_DONE) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Remember the previous accepted level so a press edge can be detected
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_levelPrev <= 1'b0;
    end else begin
      r_levelPrev <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_level & ~r_levelPrev;

endmodule

// File: rtl/example_5_4_decoder.sv
// Example 5.4 serial parity decoder with internal encoder loopback and LED display.
module example_5_4_decoder
  import example_5_4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        cp,
  input  logic        rst_n,
  input  logic [7:0]  sw_pin,
  input  logic        btn_1,
  output logic [15:0] led_pin
);

  logic [2:0] r_swSync1;
  logic [2:0] r_swSync2;
  shift3_t    r_dec;
  shift3_t    r_enc;
  logic       r_zLast;
  logic       r_err;
  logic [7:0] r_cnt;

  logic w_level;
  logic w_step;
  logic w_x;
  logic w_clear;
  logic w_loop;
  logic w_z;
  logic w_xd;
  logic w_unusedSw;

  // Switches 1..5 have no function on this board build
  assign w_unusedSw = ^sw_pin[5:1];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .cp      (cp),
    .rst_n   (rst_n),
    .i_btn   (btn_1),
    .o_level (w_level),
    .o_pulse (w_step)
  );

  // Synchronize only the switches that carry meaning: serial bit, clear and mode
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_swSync1 <= '0;
      r_swSync2 <= '0;
    end else begin
      r_swSync1 <= {sw_pin[SW_LOOP], sw_pin[SW_CLEAR], sw_pin[SW_SERIAL]};
      r_swSync2 <= r_swSync1;
    end
  end

  assign w_x     = r_swSync2[0];
  assign w_clear = r_swSync2[1];
  assign w_loop  = r_swSync2[2];

  // In loopback the encoder output is x after it has been shifted into y1, i.e. x ^ e1 ^ e2
  assign w_z  = w_loop ? (w_x ^ r_enc.b1 ^ r_enc.b2) : w_x;
  assign w_xd = w_z ^ r_dec.b1 ^ r_dec.b2;

  // Decoder, encoder, error and step counter; clear takes priority over a step
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_dec   <= '0;
      r_enc   <= '0;
      r_zLast <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_clear) begin
      r_dec   <= '0;
      r_enc   <= '0;
      r_zLast <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_dec   <= shiftIn(r_dec, w_xd);
      r_zLast <= w_z;
      r_cnt   <= r_cnt + 8'd1;
      if (w_loop) begin
        r_enc <= shiftIn(r_enc, w_x);
        if (w_xd != w_x) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Map registered state straight onto the LEDs
  always_comb begin
    led_pin                        = '0;
    led_pin[LED_D1]                = r_dec.b1;
    led_pin[LED_D2]                = r_dec.b2;
    led_pin[LED_D3]                = r_dec.b3;
    led_pin[LED_Z]                 = r_zLast;
    led_pin[LED_ZERO]              = 1'b0;
    led_pin[LED_LOOP]              = w_loop;
    led_pin[LED_ERR]               = r_err;
    led_pin[LED_BTN]               = w_level;
    led_pin[LED_CNT_LO +: 8]       = r_cnt;
  end

endmodule
